// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host transmitter definitions: FSM state encoding, command bytes, frame helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SEND     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int WD_W = 20;

    // Data bits LSB first in [7:0], odd parity in [8].
    function automatic logic [8:0] ps2_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 lines plus a falling-edge detector on the clock line.
module ps2_line_sync (
    input  logic clk,
    input  logic clr_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_q;
    logic [1:0] data_q;
    logic       clk_d;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            // NOTE: synchronizers reset to the idle-high line level so leaving reset cannot fake a falling edge.
            clk_q  <= 2'b11;
            data_q <= 2'b11;
            clk_d  <= 1'b1;
        end else begin
            clk_q  <= {clk_q[0], ps2_clk};
            data_q <= {data_q[0], ps2_data};
            clk_d  <= clk_q[1];
        end
    end

    assign clk_s  = clk_q[1];
    assign data_s = data_q[1];
    assign fall   = clk_d & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pull-low enables.
// Optional device watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5280,
    parameter int TIMEOUT_CYCLES = 720000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       clk_oe,
    output logic       data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    import ps2_host_tx_pkg::*;

    localparam int CNT_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       shift;
    logic [3:0]       bitcnt;
    logic             ackok;
    logic             clk_s;
    logic             data_s;
    logic             fall;
    logic             accept;
    logic             wd_expired;

    ps2_line_sync u_sync (
        .clk      (clk),
        .clr_n    (clr_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = tx_valid & tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
    logic [WD_W-1:0] wdog;

    // Loaded while in REQ, which always hands over to SEND on the next edge.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            wdog <= '0;
        end else if (state == ST_REQ) begin
            wdog <= WD_W'(TIMEOUT_CYCLES);
        end else if ((state inside {ST_SEND, ST_ACK, ST_WAITIDLE}) && (wdog != '0)) begin
            wdog <= wdog - 1'b1;
        end
    end

    assign wd_expired = (state inside {ST_SEND, ST_ACK, ST_WAITIDLE}) && (wdog == '0);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shift   <= '0;
            bitcnt  <= '0;
            ackok   <= 1'b0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (wd_expired) begin
                clk_oe  <= 1'b0;
                data_oe <= 1'b0;
                tx_done <= 1'b1;
                tx_err  <= 1'b1;
                state   <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            shift  <= ps2_frame(tx_data);
                            cnt    <= CNT_W'(INHIBIT_CYCLES - 1);
                            clk_oe <= 1'b1;
                            state  <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt == '0) begin
                            data_oe <= 1'b1;
                            state   <= ST_REQ;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_REQ: begin
                        clk_oe <= 1'b0;
                        bitcnt <= '0;
                        state  <= ST_SEND;
                    end
                    ST_SEND: begin
                        // The device samples on its rising edge, so each bit is set up on the falling edge.
                        if (fall) begin
                            if (bitcnt == 4'd9) begin
                                data_oe <= 1'b0;
                                state   <= ST_ACK;
                            end else begin
                                data_oe <= ~shift[bitcnt];
                                bitcnt  <= bitcnt + 4'd1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (fall) begin
                            ackok <= ~data_s;
                            state <= ST_WAITIDLE;
                        end
                    end
                    ST_WAITIDLE: begin
                        if (clk_s && data_s) begin
                            tx_done <= 1'b1;
                            tx_err  <= ~ackok;
                            state   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 keyboard model on the open-drain lines.
// Watchdog scenario follows PS2_TX_TIMEOUT_EN.
module tb_ps2_host_tx;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    int viol = 0;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_oe   (clk_oe),
        .data_oe  (data_oe),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    // Pre-edge values seen at posedge: counts accepts and done pulses, flags illegal output combinations.
    always @(posedge clk) begin
        if (clr_n) begin
            if (tx_done) done_cnt++;
            if (tx_valid && tx_ready) accept_cnt++;
            if (busy && tx_ready) viol++;
            if ((clk_oe || data_oe) && !busy) viol++;
            if (tx_done && (clk_oe || data_oe)) viol++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_release(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!clk_oe && data_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Keyboard model: sample the data line, then pulse the clock low; optional ACK on the 11th clock.
    task automatic dev_clocks(input int nclk, input bit do_ack, output logic [10:0] got);
        got = '1;
        for (int i = 0; i < nclk; i++) begin
            repeat (2 * HALF) @(negedge clk);
            got[i] = ps2_data;
            if (i == 10 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (dev_data_low) begin
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic err, output int cyc);
        seen = 1'b0;
        err  = 1'bx;
        cyc  = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (tx_done) begin
                seen = 1'b1;
                err  = tx_err;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit do_ack,
                              output logic [10:0] frame, output bit seen, output logic err);
        bit ok;
        int cyc;
        start_tx(d);
        wait_release(ok);
        if (!ok) begin
            frame = 'x;
            seen  = 1'b0;
            err   = 1'bx;
        end else begin
            dev_clocks(11, do_ack, frame);
            wait_done(100, seen, err, cyc);
        end
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_ready, busy, clk_oe, data_oe, tx_done, tx_err} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_state: got ready/busy/clk_oe/data_oe/done/err=%b want 100000",
                     {tx_ready, busy, clk_oe, data_oe, tx_done, tx_err});
        end
        clr_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_set_leds;
        int n;
        logic [10:0] frame;
        bit seen;
        logic err;
        int cyc;
        start_tx(8'hED);
        n = 0;
        while (clk_oe && !data_oe && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL inhibit_len: got %0d cycles want 8", n);
        end
        total++;
        if ({clk_oe, data_oe} !== 2'b11) begin
            bad++;
            $display("FAIL req_both_low: got clk_oe/data_oe=%b want 11", {clk_oe, data_oe});
        end
        @(negedge clk);
        total++;
        if ({clk_oe, data_oe} !== 2'b01) begin
            bad++;
            $display("FAIL clk_release: got clk_oe/data_oe=%b want 01", {clk_oe, data_oe});
        end
        dev_clocks(11, 1'b1, frame);
        total++;
        if (frame !== 11'b11_11101101_0) begin
            bad++;
            $display("FAIL frame_ED: got %b want %b", frame, 11'b11_11101101_0);
        end
        wait_done(100, seen, err, cyc);
        total++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL done_ED: got done=%b err=%b want done=1 err=0", seen, err);
        end
    endtask

    task automatic test_parity;
        logic [10:0] frame;
        bit seen;
        logic err;
        send_frame(8'h00, 1'b1, frame, seen, err);
        total++;
        if (frame !== 11'b11_00000000_0) begin
            bad++;
            $display("FAIL frame_00: got %b want %b", frame, 11'b11_00000000_0);
        end
        total++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL done_00: got done=%b err=%b want done=1 err=0", seen, err);
        end
        send_frame(8'h01, 1'b1, frame, seen, err);
        total++;
        if (frame !== 11'b10_00000001_0) begin
            bad++;
            $display("FAIL frame_01: got %b want %b", frame, 11'b10_00000001_0);
        end
        total++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL done_01: got done=%b err=%b want done=1 err=0", seen, err);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] frame;
        bit seen;
        logic err;
        send_frame(8'hED, 1'b0, frame, seen, err);
        total++;
        if (frame !== 11'b11_11101101_0) begin
            bad++;
            $display("FAIL frame_noack: got %b want %b", frame, 11'b11_11101101_0);
        end
        total++;
        if (seen !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL done_noack: got done=%b err=%b want done=1 err=1", seen, err);
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        bit seen;
        logic err;
        int cyc;
        start_tx(8'h00);
        wait_release(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_release: got no release want clk_oe=0 data_oe=1");
        end
        wait_done(400, seen, err, cyc);
        total++;
        if (seen !== 1'b1 || err !== 1'b1 || cyc < 195 || cyc > 210) begin
            bad++;
            $display("FAIL timeout_done: got done=%b err=%b after %0d want done=1 err=1 after ~201",
                     seen, err, cyc);
        end
        total++;
        if ({clk_oe, data_oe} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_lines: got clk_oe/data_oe=%b want 00", {clk_oe, data_oe});
        end
        repeat (3) @(negedge clk);
    endtask
`else
    task automatic test_no_timeout;
        bit ok;
        bit seen;
        logic err;
        int cyc;
        start_tx(8'h00);
        wait_release(ok);
        wait_done(400, seen, err, cyc);
        total++;
        if (seen !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL silent_device: got done=%b busy=%b want done=0 busy=1", seen, busy);
        end
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        total++;
        if (busy !== 1'b0 || data_oe !== 1'b0) begin
            bad++;
            $display("FAIL silent_recover: got busy=%b data_oe=%b want 0 0", busy, data_oe);
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_mid_reset;
        bit ok;
        logic [10:0] frame;
        bit seen;
        logic err;
        int d0;
        start_tx(8'h55);
        wait_release(ok);
        dev_clocks(4, 1'b0, frame);
        total++;
        if (frame[3:0] !== 4'b1010) begin
            bad++;
            $display("FAIL partial_55: got %b want 1010", frame[3:0]);
        end
        d0 = done_cnt;
        clr_n = 1'b0;
        @(negedge clk);
        total++;
        if ({clk_oe, data_oe, busy, tx_done} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset: got clk_oe/data_oe/busy/done=%b want 0000",
                     {clk_oe, data_oe, busy, tx_done});
        end
        clr_n = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL mid_reset_done: got %0d pulses want 0", done_cnt - d0);
        end
        send_frame(8'hFF, 1'b1, frame, seen, err);
        total++;
        if (frame !== 11'b11_11111111_0) begin
            bad++;
            $display("FAIL frame_FF: got %b want %b", frame, 11'b11_11111111_0);
        end
        total++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL done_FF: got done=%b err=%b want done=1 err=0", seen, err);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [10:0] frame;
        bit seen;
        logic err;
        int cyc;
        int a0;
        int d0;
        @(negedge clk);
        a0 = accept_cnt;
        d0 = done_cnt;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_release(ok);
            dev_clocks(11, 1'b1, frame);
            total++;
            if (frame !== 11'b10_00000001_0) begin
                bad++;
                $display("FAIL b2b_frame%0d: got %b want %b", k, frame, 11'b10_00000001_0);
            end
            wait_done(100, seen, err, cyc);
            total++;
            if (seen !== 1'b1 || tx_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_done%0d: got done=%b ready=%b want done=1 ready=0", k, seen, tx_ready);
            end
            @(negedge clk);
            total++;
            if (tx_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d: got %b want 1", k, tx_ready);
            end
            if (k == 1) tx_valid = 1'b0;
        end
        repeat (20) @(negedge clk);
        total++;
        if (accept_cnt - a0 != 2 || done_cnt - d0 != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_counts: got accepts=%0d dones=%0d busy=%b want 2 2 0",
                     accept_cnt - a0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_invariants;
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL invariants: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_no_ack();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_mid_reset();
        test_back_to_back();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
